// File: rtl/dft_reorder_buf.sv
// dft_reorder_buf: output reorder buffer for a radix-3-first mixed-radix SDF
// DFT pipeline of length N = 3*2^M. Frames arrive in digit-reversed order
// (p = g*2^M + j) and leave in natural order k = g + 3*bitrev_M(j).
// Two N-word banks ping-pong: one bank fills while the other drains.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   on              stage enable; low aborts the frame being written
//   di_en/re/im     input sample valid, real, imaginary (WIDTH bits)
//   do_en/re/im     output sample valid, real, imaginary (WIDTH bits)
//   do_sof          start-of-frame flag on k=0 (only with DFT_REORDER_SOF_EN)
//
// Optional feature macro: DFT_REORDER_SOF_EN adds the do_sof output.
module dft_reorder_buf #(
  parameter int unsigned WIDTH = 14,
  parameter int unsigned M     = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             on,
  input  logic             di_en,
  input  logic [WIDTH-1:0] di_re,
  input  logic [WIDTH-1:0] di_im,
  output logic             do_en,
  output logic [WIDTH-1:0] do_re,
  output logic [WIDTH-1:0] do_im
`ifdef DFT_REORDER_SOF_EN
  ,
  output logic             do_sof
`endif
);

  localparam int unsigned J  = 1 << M;
  localparam int unsigned N  = 3 * J;
  localparam int unsigned JW = (M > 0) ? M : 1;
  localparam int unsigned RW = $clog2(N);
  localparam int unsigned AW = $clog2(2 * N);

  localparam logic [JW-1:0] J_LAST = JW'(J - 1);
  localparam logic [RW-1:0] R_LAST = RW'(N - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] READ = 1'b1;

  // Reverse the low M bits of the power-of-two digit.
  function automatic logic [JW-1:0] bitrev(input logic [JW-1:0] x);
    logic [JW-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < M; i++) begin
      r[i] = x[M-1-i];
    end
    return r;
  endfunction

  logic [0:0]    state_q, state_d;
  logic [1:0]    g_q, g_d;
  logic [JW-1:0] j_q, j_d;
  logic          wbank_q, wbank_d;
  logic          rbank_q, rbank_d;
  logic [RW-1:0] raddr_q, raddr_d;
  logic          s1_vld_q;
  logic          do_en_q;

  logic [WIDTH-1:0] mem_re [2*N];
  logic [WIDTH-1:0] mem_im [2*N];
  logic [WIDTH-1:0] s1_re_q, s1_im_q;
  logic [WIDTH-1:0] do_re_q, do_im_q;

  logic          we_c;
  logic          frame_done_c;
  logic          rd_issue_c;
  logic [AW-1:0] waddr_c;
  logic [AW-1:0] raddr_full_c;

  assign we_c         = on & di_en;
  assign frame_done_c = we_c && (g_q == 2'd2) && (j_q == J_LAST);

  // Samples land at their natural index, so the reader simply counts up.
  assign waddr_c      = (wbank_q ? AW'(N) : AW'(0)) + AW'(g_q) + AW'(3 * bitrev(j_q));
  assign raddr_full_c = (rbank_q ? AW'(N) : AW'(0)) + AW'(raddr_q);

  // Write counters, bank pointers and reader FSM next state.
  always_comb begin
    state_d    = state_q;
    g_d        = g_q;
    j_d        = j_q;
    wbank_d    = wbank_q;
    rbank_d    = rbank_q;
    raddr_d    = raddr_q;
    rd_issue_c = 1'b0;

    if (!on) begin
      g_d = '0;
      j_d = '0;
    end else if (di_en) begin
      if (j_q == J_LAST) begin
        j_d = '0;
        g_d = (g_q == 2'd2) ? 2'd0 : g_q + 2'd1;
      end else begin
        j_d = j_q + JW'(1);
      end
    end

    if (frame_done_c) wbank_d = ~wbank_q;

    case (state_q)
      IDLE: begin
        if (frame_done_c) begin
          state_d = READ;
          raddr_d = '0;
          rbank_d = wbank_q;
        end
      end
      READ: begin
        rd_issue_c = 1'b1;
        if (raddr_q == R_LAST) begin
          // A frame completing on the final read edge chains straight on.
          if (frame_done_c) begin
            raddr_d = '0;
            rbank_d = wbank_q;
          end else begin
            state_d = IDLE;
          end
        end else begin
          raddr_d = raddr_q + RW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      g_q      <= '0;
      j_q      <= '0;
      wbank_q  <= 1'b0;
      rbank_q  <= 1'b0;
      raddr_q  <= '0;
      s1_vld_q <= 1'b0;
      do_en_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      g_q      <= g_d;
      j_q      <= j_d;
      wbank_q  <= wbank_d;
      rbank_q  <= rbank_d;
      raddr_q  <= raddr_d;
      s1_vld_q <= rd_issue_c;
      do_en_q  <= s1_vld_q;
    end
  end

  // Bank memories and data pipeline; not reset.
  always_ff @(posedge clk) begin
    if (we_c) begin
      mem_re[waddr_c] <= di_re;
      mem_im[waddr_c] <= di_im;
    end
    if (rd_issue_c) begin
      s1_re_q <= mem_re[raddr_full_c];
      s1_im_q <= mem_im[raddr_full_c];
    end
    if (s1_vld_q) begin
      do_re_q <= s1_re_q;
      do_im_q <= s1_im_q;
    end
  end

  assign do_en = do_en_q;
  assign do_re = do_re_q;
  assign do_im = do_im_q;

`ifdef DFT_REORDER_SOF_EN
  logic s1_sof_q;
  logic do_sof_q;

  // Start-of-frame travels alongside the k=0 read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_sof_q <= 1'b0;
      do_sof_q <= 1'b0;
    end else begin
      s1_sof_q <= rd_issue_c && (raddr_q == '0);
      do_sof_q <= s1_sof_q;
    end
  end

  assign do_sof = do_sof_q;
`endif

endmodule

// File: tb/tb_dft_reorder_buf.sv
// Directed testbench for dft_reorder_buf (WIDTH=14, M=2, N=12).
module tb_dft_reorder_buf;

  localparam int W  = 14;
  localparam int NN = 12;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         on    = 1'b0;
  logic         di_en = 1'b0;
  logic [W-1:0] di_re = '0;
  logic [W-1:0] di_im = '0;
  logic         do_en;
  logic [W-1:0] do_re;
  logic [W-1:0] do_im;
`ifdef DFT_REORDER_SOF_EN
  logic         do_sof;
`endif

  always #5 clk = ~clk;

  dft_reorder_buf #(.WIDTH(W), .M(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .on    (on),
    .di_en (di_en),
    .di_re (di_re),
    .di_im (di_im),
    .do_en (do_en),
    .do_re (do_re),
    .do_im (do_im)
`ifdef DFT_REORDER_SOF_EN
    ,
    .do_sof(do_sof)
`endif
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [W-1:0] q_re[$];
  logic [W-1:0] q_im[$];
  int           q_cyc[$];
  logic         q_sof[$];

  // Capture every valid output away from the active edge.
  always @(negedge clk) begin
    if (do_en === 1'b1) begin
      q_re.push_back(do_re);
      q_im.push_back(do_im);
      q_cyc.push_back(cyc);
`ifdef DFT_REORDER_SOF_EN
      q_sof.push_back(do_sof);
`else
      q_sof.push_back(1'b0);
`endif
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Hand-derived natural-order source positions for M=2.
  int exp_p[NN] = '{0, 4, 8, 2, 6, 10, 1, 5, 9, 3, 7, 11};

  task automatic clear_q();
    q_re.delete(); q_im.delete(); q_cyc.delete(); q_sof.delete();
  endtask

  task automatic drive_idle(input int n);
    repeat (n) begin
      @(negedge clk);
      di_en = 1'b0;
    end
  endtask

  // One frame of di_re = base+p, di_im = -(base+p), optional gap after gap_after.
  task automatic send_frame(input int base, input int gap_after, input int gap_len,
                            output int first_acc, output int last_acc);
    first_acc = 0;
    last_acc  = 0;
    for (int p = 0; p < NN; p++) begin
      @(negedge clk);
      on    = 1'b1;
      di_en = 1'b1;
      di_re = W'(base + p);
      di_im = W'(-(base + p));
      if (p == 0)      first_acc = cyc + 1;
      if (p == NN - 1) last_acc  = cyc + 1;
      if (p == gap_after) begin
        repeat (gap_len) begin
          @(negedge clk);
          di_en = 1'b0;
        end
      end
    end
  endtask

  task automatic wait_outputs(input int n);
    int t;
    t = 0;
    while (q_re.size() < n && t < 200) begin
      @(negedge clk);
      t++;
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (do_en !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_do_en: got %b want 0", do_en);
    end
    rst_n = 1'b1;
    on    = 1'b1;
    drive_idle(5);
    n_checks++;
    if (q_re.size() != 0) begin
      n_fail++;
      $display("FAIL reset_idle_out: got %0d outputs want 0", q_re.size());
    end
  endtask

  task automatic test_single();
    int fa, la;
    clear_q();
    send_frame(0, -1, 0, fa, la);
    drive_idle(1);
    wait_outputs(NN);
    n_checks++;
    if (q_re.size() != NN) begin
      n_fail++;
      $display("FAIL single_count: got %0d want %0d", q_re.size(), NN);
    end else begin
      for (int i = 0; i < NN; i++) begin
        n_checks++;
        if (q_re[i] !== W'(exp_p[i]) || q_im[i] !== W'(-exp_p[i])) begin
          n_fail++;
          $display("FAIL single_data k=%0d: got re=%0d im=%0d want re=%0d im=%0d",
                   i, q_re[i], q_im[i], W'(exp_p[i]), W'(-exp_p[i]));
        end
      end
      n_checks++;
      if (q_cyc[0] != la + 2) begin
        n_fail++;
        $display("FAIL single_latency: got cycle %0d want %0d", q_cyc[0], la + 2);
      end
      n_checks++;
      if (q_cyc[NN-1] != q_cyc[0] + NN - 1) begin
        n_fail++;
        $display("FAIL single_contig: got last cycle %0d want %0d", q_cyc[NN-1], q_cyc[0] + NN - 1);
      end
    end
  endtask

  task automatic test_back_to_back();
    int fa, la, la0, nsof;
    clear_q();
    la0 = 0;
    for (int f = 0; f < 3; f++) begin
      send_frame(100 * f, -1, 0, fa, la);
      if (f == 0) la0 = la;
    end
    drive_idle(1);
    wait_outputs(3 * NN);
    n_checks++;
    if (q_re.size() != 3 * NN) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d want %0d", q_re.size(), 3 * NN);
    end else begin
      nsof = 0;
      for (int f = 0; f < 3; f++) begin
        for (int i = 0; i < NN; i++) begin
          n_checks++;
          if (q_re[f*NN+i] !== W'(100*f + exp_p[i]) || q_im[f*NN+i] !== W'(-(100*f + exp_p[i]))) begin
            n_fail++;
            $display("FAIL b2b_data f=%0d k=%0d: got re=%0d want re=%0d",
                     f, i, q_re[f*NN+i], W'(100*f + exp_p[i]));
          end
`ifdef DFT_REORDER_SOF_EN
          if (q_sof[f*NN+i] === 1'b1) nsof++;
          n_checks++;
          if (q_sof[f*NN+i] !== (i == 0)) begin
            n_fail++;
            $display("FAIL b2b_sof f=%0d k=%0d: got %b want %b", f, i, q_sof[f*NN+i], (i == 0));
          end
`endif
        end
      end
`ifdef DFT_REORDER_SOF_EN
      n_checks++;
      if (nsof != 3) begin
        n_fail++;
        $display("FAIL b2b_sof_count: got %0d want 3", nsof);
      end
`endif
      n_checks++;
      if (q_cyc[0] != la0 + 2 || q_cyc[3*NN-1] != q_cyc[0] + 3*NN - 1) begin
        n_fail++;
        $display("FAIL b2b_timing: got first %0d last %0d want first %0d last %0d",
                 q_cyc[0], q_cyc[3*NN-1], la0 + 2, la0 + 2 + 3*NN - 1);
      end
    end
  endtask

  task automatic test_gap();
    int fa, la;
    clear_q();
    send_frame(0, 5, 3, fa, la);
    drive_idle(1);
    wait_outputs(NN);
    n_checks++;
    if (q_re.size() != NN) begin
      n_fail++;
      $display("FAIL gap_count: got %0d want %0d", q_re.size(), NN);
    end else begin
      for (int i = 0; i < NN; i++) begin
        n_checks++;
        if (q_re[i] !== W'(exp_p[i]) || q_im[i] !== W'(-exp_p[i])) begin
          n_fail++;
          $display("FAIL gap_data k=%0d: got re=%0d want re=%0d", i, q_re[i], W'(exp_p[i]));
        end
      end
      n_checks++;
      if (q_cyc[0] != fa + (NN - 1) + 3 + 2) begin
        n_fail++;
        $display("FAIL gap_latency: got cycle %0d want %0d", q_cyc[0], fa + (NN - 1) + 3 + 2);
      end
    end
  endtask

  task automatic test_abort();
    int fa, la;
    clear_q();
    for (int p = 0; p < 8; p++) begin
      @(negedge clk);
      on    = 1'b1;
      di_en = 1'b1;
      di_re = W'(500 + p);
      di_im = W'(-(500 + p));
    end
    @(negedge clk);
    on    = 1'b0;
    di_en = 1'b1;
    di_re = W'(999);
    di_im = W'(999);
    send_frame(200, -1, 0, fa, la);
    drive_idle(1);
    wait_outputs(NN);
    n_checks++;
    if (q_re.size() != NN) begin
      n_fail++;
      $display("FAIL abort_count: got %0d want %0d", q_re.size(), NN);
    end else begin
      for (int i = 0; i < NN; i++) begin
        n_checks++;
        if (q_re[i] !== W'(200 + exp_p[i]) || q_im[i] !== W'(-(200 + exp_p[i]))) begin
          n_fail++;
          $display("FAIL abort_data k=%0d: got re=%0d want re=%0d", i, q_re[i], W'(200 + exp_p[i]));
        end
      end
      n_checks++;
      if (q_cyc[0] != la + 2) begin
        n_fail++;
        $display("FAIL abort_latency: got cycle %0d want %0d", q_cyc[0], la + 2);
      end
    end
  endtask

  task automatic test_reset_mid_read();
    int fa, la, t;
    clear_q();
    send_frame(300, -1, 0, fa, la);
    drive_idle(1);
    t = 0;
    while (!(do_en === 1'b1 && do_re === W'(300 + exp_p[4])) && t < 100) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (t >= 100) begin
      n_fail++;
      $display("FAIL rst_mid_reach_k4: got timeout want k=4 output");
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (do_en !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_async: got do_en=%b want 0", do_en);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive_idle(20);
    n_checks++;
    if (q_re.size() != 5) begin
      n_fail++;
      $display("FAIL rst_mid_quiet: got %0d outputs want 5", q_re.size());
    end
    clear_q();
    send_frame(400, -1, 0, fa, la);
    drive_idle(1);
    wait_outputs(NN);
    n_checks++;
    if (q_re.size() != NN) begin
      n_fail++;
      $display("FAIL rst_mid_new_count: got %0d want %0d", q_re.size(), NN);
    end else begin
      for (int i = 0; i < NN; i++) begin
        n_checks++;
        if (q_re[i] !== W'(400 + exp_p[i])) begin
          n_fail++;
          $display("FAIL rst_mid_new_data k=%0d: got re=%0d want re=%0d", i, q_re[i], W'(400 + exp_p[i]));
        end
      end
      n_checks++;
      if (q_cyc[0] != la + 2) begin
        n_fail++;
        $display("FAIL rst_mid_new_latency: got cycle %0d want %0d", q_cyc[0], la + 2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_gap();
    test_abort();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
